// File: rtl/miriscv_gpr_pkg.sv
// Shared constants and types for the miriscv GPR file: depth selection and pending bitmap.
package miriscv_gpr_pkg;

  localparam int GPR_MAX_DEPTH = 32;
  localparam int ZERO_REG      = 0;

  // Wide enough for RV32I; RV32E only ever touches the lower 16 bits.
  typedef logic [GPR_MAX_DEPTH-1:0] gpr_pend_t;

  function automatic int gpr_addr_width(input int rv_e);
    return 5 - rv_e;
  endfunction

  function automatic int gpr_depth(input int rv_e);
    return 1 << gpr_addr_width(rv_e);
  endfunction

endpackage

// File: rtl/miriscv_gpr_file_if.sv
// Decode/writeback side bundle for the GPR file.
// No handshake: every strobe (wr_en_i, rsv_en_i, flush_i) is accepted on the clock edge that samples it.
interface miriscv_gpr_file_if
  import miriscv_gpr_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RISCV_E      = 0,
  parameter int NUM_RD_PORTS = 2
);

  localparam int AW = gpr_addr_width(RISCV_E);

  logic [NUM_RD_PORTS*AW-1:0]   rd_addr_i;
  logic [NUM_RD_PORTS*XLEN-1:0] rd_data_o;
  logic [NUM_RD_PORTS-1:0]      rd_busy_o;
  logic                         wr_en_i;
  logic [AW-1:0]                wr_addr_i;
  logic [XLEN-1:0]              wr_data_i;
  logic                         rsv_en_i;
  logic [AW-1:0]                rsv_addr_i;
  logic                         flush_i;
  logic                         busy_any_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_any_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
    output rd_data_o, rd_busy_o, busy_any_o
  );

endinterface

// File: rtl/miriscv_gpr_scoreboard.sv
// Pending-write bitmap: issue reserves a destination, writeback releases it, flush clears all.
module miriscv_gpr_scoreboard
  import miriscv_gpr_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          rsv_en_i,
  input  logic [AW-1:0] rsv_addr_i,
  input  logic          rel_en_i,
  input  logic [AW-1:0] rel_addr_i,
  input  logic          flush_i,
  output gpr_pend_t     pend_o,
  output logic          busy_any_o
);

  gpr_pend_t r_pend;
  gpr_pend_t w_pend_nxt;

  // Release is applied before reserve so a new producer on the same register keeps it pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (rel_en_i) w_pend_nxt[rel_addr_i] = 1'b0;
    if (rsv_en_i && (rsv_addr_i != AW'(ZERO_REG))) w_pend_nxt[rsv_addr_i] = 1'b1;
    if (flush_i) w_pend_nxt = '0;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_pend <= '0;
    else          r_pend <= w_pend_nxt;
  end

  assign pend_o     = r_pend;
  assign busy_any_o = |r_pend;

endmodule

// File: rtl/miriscv_gpr_file.sv
// miriscv general-purpose register file with pending-write scoreboard.
// Optional write-through forwarding: define MIRISCV_GPR_BYPASS_EN.
module miriscv_gpr_file
  import miriscv_gpr_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RISCV_E      = 0,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  miriscv_gpr_file_if.slave    bus
);

  localparam int AW    = gpr_addr_width(RISCV_E);
  localparam int DEPTH = gpr_depth(RISCV_E);

  logic [XLEN-1:0]              r_regs [1:DEPTH-1];
  gpr_pend_t                    w_pend;
  logic                         w_wr_hit;
  logic [NUM_RD_PORTS*XLEN-1:0] w_rd_data;
  logic [NUM_RD_PORTS-1:0]      w_rd_busy;

  assign w_wr_hit = bus.wr_en_i && (bus.wr_addr_i != AW'(ZERO_REG));

  // x0 has no storage; the loop starts at 1.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 1; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_wr_hit && (bus.wr_addr_i == AW'(i))) r_regs[i] <= bus.wr_data_i;
      end
    end
  end

  miriscv_gpr_scoreboard #(.AW(AW)) u_scoreboard (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .rsv_en_i   (bus.rsv_en_i),
    .rsv_addr_i (bus.rsv_addr_i),
    .rel_en_i   (w_wr_hit),
    .rel_addr_i (bus.wr_addr_i),
    .flush_i    (bus.flush_i),
    .pend_o     (w_pend),
    .busy_any_o (bus.busy_any_o)
  );

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      logic [AW-1:0] v_addr;
      v_addr = bus.rd_addr_i[p*AW +: AW];
      for (int i = 1; i < DEPTH; i++) begin
        if (v_addr == AW'(i)) w_rd_data[p*XLEN +: XLEN] = r_regs[i];
      end
      w_rd_busy[p] = (v_addr != AW'(ZERO_REG)) && w_pend[v_addr];
`ifdef MIRISCV_GPR_BYPASS_EN
      // Forwarding is gated by reset so outputs stay at zero while reset is held.
      if (arstn_i && w_wr_hit && (v_addr == bus.wr_addr_i)) begin
        w_rd_data[p*XLEN +: XLEN] = bus.wr_data_i;
        w_rd_busy[p] = bus.rsv_en_i && (bus.rsv_addr_i == v_addr);
      end
`endif
    end
  end

  assign bus.rd_data_o = w_rd_data;
  assign bus.rd_busy_o = w_rd_busy;

endmodule

// File: tb/tb_miriscv_gpr_file.sv
// Scoreboarded bench for miriscv_gpr_file: RV32I two-port instance plus an RV32E one-port instance.
module tb_miriscv_gpr_file;
  import miriscv_gpr_pkg::*;

  localparam int XLEN = 32;
  localparam int NRP  = 2;
  localparam int W    = NRP*XLEN + NRP + 1;

  logic clk = 1'b0;
  logic arstn;
  logic arstn_e;

  always #5 clk = ~clk;

  miriscv_gpr_file_if #(.XLEN(XLEN), .RISCV_E(0), .NUM_RD_PORTS(NRP)) bus ();
  miriscv_gpr_file_if #(.XLEN(XLEN), .RISCV_E(1), .NUM_RD_PORTS(1))   bus_e ();

  miriscv_gpr_file #(.XLEN(XLEN), .RISCV_E(0), .NUM_RD_PORTS(NRP)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  miriscv_gpr_file #(.XLEN(XLEN), .RISCV_E(1), .NUM_RD_PORTS(1)) dut_e (
    .clk_i   (clk),
    .arstn_i (arstn_e),
    .bus     (bus_e)
  );

  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] exp_e_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit e_done = 1'b0;

  // Reference state: plain arrays of register values and pending flags.
  logic [XLEN-1:0] m_reg [32];
  bit              m_pend[32];
  logic [XLEN-1:0] e_reg [16];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
  endtask

  task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit re, input logic [4:0] ra, input bit fl,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input bit rst_now, input bit rst_rel);
    logic [NRP*XLEN-1:0] ed;
    logic [NRP-1:0]      eb;
    bit                  ea;
    logic [4:0]          ad[NRP];
    logic [XLEN-1:0]     d;
    bit                  b;
    @(posedge clk); #1;
    if (rst_now) arstn = 1'b0;
    if (rst_rel) arstn = 1'b1;
    if (!arstn) model_reset();
    bus.wr_en_i = we; bus.wr_addr_i = wa; bus.wr_data_i = wd;
    bus.rsv_en_i = re; bus.rsv_addr_i = ra; bus.flush_i = fl;
    bus.rd_addr_i = {a1, a0};
    ad[0] = a0; ad[1] = a1;
    ea = 1'b0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) ea = 1'b1;
    for (int p = 0; p < NRP; p++) begin
      d = (ad[p] == 0) ? '0 : m_reg[ad[p]];
      b = (ad[p] != 0) && m_pend[ad[p]];
`ifdef MIRISCV_GPR_BYPASS_EN
      if (arstn && we && wa != 0 && ad[p] == wa) begin
        d = wd;
        b = re && (ra == wa);
      end
`endif
      ed[p*XLEN +: XLEN] = d;
      eb[p] = b;
    end
    exp_q.push_back({ed, eb, ea});
    // State the coming edge will commit.
    if (arstn) begin
      if (we && wa != 0) m_reg[wa] = wd;
      if (fl) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
        if (we) m_pend[wa] = 1'b0;
        if (re && ra != 0) m_pend[ra] = 1'b1;
      end
    end
  endtask

  task automatic drive_e(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] a, input bit rel);
    logic [XLEN-1:0] d;
    @(posedge clk); #1;
    if (rel) arstn_e = 1'b1;
    bus_e.wr_en_i = we; bus_e.wr_addr_i = wa; bus_e.wr_data_i = wd;
    bus_e.rsv_en_i = 1'b0; bus_e.rsv_addr_i = '0; bus_e.flush_i = 1'b0;
    bus_e.rd_addr_i = a;
    d = (a == 0 || !arstn_e) ? '0 : e_reg[a];
`ifdef MIRISCV_GPR_BYPASS_EN
    if (arstn_e && we && wa != 0 && a == wa) d = wd;
`endif
    exp_e_q.push_back(d);
    if (arstn_e && we && wa != 0) e_reg[wa] = wd;
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  // Monitor: outputs are combinational, so every negedge presents one response.
  initial begin
    logic [W-1:0] e;
    logic [XLEN-1:0] ee;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.rd_data_o !== e[W-1 -: NRP*XLEN]) begin
          n_err++;
          $display("FAIL rd_data t=%0t got %h expected %h", $time, bus.rd_data_o, e[W-1 -: NRP*XLEN]);
        end
        n_vec++;
        if (bus.rd_busy_o !== e[NRP:1]) begin
          n_err++;
          $display("FAIL rd_busy t=%0t got %b expected %b", $time, bus.rd_busy_o, e[NRP:1]);
        end
        n_vec++;
        if (bus.busy_any_o !== e[0]) begin
          n_err++;
          $display("FAIL busy_any t=%0t got %b expected %b", $time, bus.busy_any_o, e[0]);
        end
      end
      if (exp_e_q.size() > 0) begin
        ee = exp_e_q.pop_front();
        n_vec++;
        if (bus_e.rd_data_o !== ee) begin
          n_err++;
          $display("FAIL rv32e_rd_data t=%0t got %h expected %h", $time, bus_e.rd_data_o, ee);
        end
        n_vec++;
        if ({bus_e.rd_busy_o, bus_e.busy_any_o} !== 2'b00) begin
          n_err++;
          $display("FAIL rv32e_busy t=%0t got %b expected 00", $time, {bus_e.rd_busy_o, bus_e.busy_any_o});
        end
      end
    end
  end

  // RV32E instance: depth 16, x0 hardwired.
  initial begin
    arstn_e = 1'b0;
    for (int i = 0; i < 16; i++) e_reg[i] = '0;
    bus_e.wr_en_i = 1'b0; bus_e.wr_addr_i = '0; bus_e.wr_data_i = '0;
    bus_e.rsv_en_i = 1'b0; bus_e.rsv_addr_i = '0; bus_e.flush_i = 1'b0; bus_e.rd_addr_i = '0;
    drive_e(1'b1, 4'd15, 32'h1, 4'd15, 1'b0);
    drive_e(1'b1, 4'd15, 32'h1, 4'd15, 1'b1);
    drive_e(1'b0, 4'd0, 32'h0, 4'd15, 1'b0);
    for (int i = 0; i < 16; i++)
      drive_e(1'b1, 4'(i), 32'hE000_0000 | 32'(i), 4'(i), 1'b0);
    for (int i = 0; i < 16; i++)
      drive_e(1'b0, 4'd0, 32'h0, 4'(i), 1'b0);
    for (int k = 0; k < 150; k++)
      drive_e(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
              4'($urandom_range(0, 15)), 1'b0);
    e_done = 1'b1;
  end

  initial begin
    int rst_cnt;
    bit rn, rr;
    arstn = 1'b0;
    model_reset();
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.rsv_en_i = 1'b0; bus.rsv_addr_i = '0; bus.flush_i = 1'b0; bus.rd_addr_i = '0;

    // Reset held, then x0 write/reserve must be ignored.
    drive(1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 0, 5'd5, 5'd0, 1, 0);
    drive(1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 0, 5'd5, 5'd0, 0, 1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 5'd5, 0, 0);
    // Basic write then dual-port read.
    drive(1, 5'd5, 32'h1234_5678, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd5, 5'd5, 0, 0);
    // Reserve then release of x7.
    drive(0, 5'd0, 32'h0, 1, 5'd7, 0, 5'd7, 5'd0, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd7, 5'd7, 0, 0);
    drive(1, 5'd7, 32'hA5, 0, 5'd0, 0, 5'd7, 5'd0, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd7, 5'd7, 0, 0);
    // Same-cycle reserve and write on x9.
    drive(1, 5'd10, 32'h1111, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    drive(1, 5'd9, 32'h99, 1, 5'd9, 0, 5'd9, 5'd10, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd9, 5'd9, 0, 0);
    // Flush beats reserve but not write.
    drive(0, 5'd0, 32'h0, 1, 5'd8, 0, 5'd8, 5'd9, 0, 0);
    drive(1, 5'd4, 32'h55, 1, 5'd3, 1, 5'd3, 5'd4, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd3, 5'd4, 0, 0);
    // Same-cycle write/read of x10.
    drive(1, 5'd10, 32'hCAFE, 0, 5'd0, 0, 5'd10, 5'd10, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd10, 5'd10, 0, 0);

    rst_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      rn = 1'b0; rr = 1'b0;
      if (rst_cnt == 0 && $urandom_range(0, 99) == 0) begin
        rn = 1'b1; rst_cnt = 2;
      end else if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rr = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 2) == 0), rnd_addr(), 1'($urandom_range(0, 19) == 0),
            rnd_addr(), rnd_addr(), rn, rr);
    end
    if (!arstn) drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd1, 5'd2, 0, 0);

    for (int k = 0; k < 2000 && !e_done; k++) @(posedge clk);
    repeat (2) @(negedge clk);
    n_vec++;
    if (!e_done || exp_q.size() != 0 || exp_e_q.size() != 0) begin
      n_err++;
      $display("FAIL drain done=%0b pending=%0d/%0d expected 1 0/0", e_done, exp_q.size(), exp_e_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
